// File: rtl/act_pwl_simd.sv
// act_pwl_simd: LANES-wide piecewise-linear tanh/sigmoid, 3-stage valid/ready pipeline
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_data input beat;
//   out_valid/out_ready/out_mode/out_data output beat. Lane k sits at [k*DATA_W +: DATA_W],
//   signed Q(DATA_W-FRAC_W).FRAC_W. Macro ACT_PWL_SIGMOID_EN enables sigmoid (in_mode=1);
//   without it every beat is tanh and out_mode is 0.
module act_pwl_simd #(
  parameter int LANES  = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic [LANES*DATA_W-1:0] out_data
);
  localparam real SCALE = real'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] LIM  = DATA_W'((1 << FRAC_W) - 1);
  localparam logic signed [DATA_W-1:0] HALF = DATA_W'(1 << (FRAC_W - 1));
  localparam logic signed [DATA_W-1:0] MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [2*DATA_W-1:0] RND = (2*DATA_W)'(1 << (FRAC_W - 1));
  function automatic real th(input int k);
    case (k)
      1: return 0.46211715726000974;
      2: return 0.76159415595576489;
      3: return 0.90514825364486640;
      4: return 0.96402758007581690;
      5: return 0.98661429815143030;
      6: return 0.99505475368673050;
      default: return 0.0;
    endcase
  endfunction
  // chord through tanh at 0.5k and 0.5(k+1): slope 2*(Tb-Ta), intercept Ta - slope*0.5k
  function automatic logic [DATA_W-1:0] m_q(input int k);
    return k < 6 ? DATA_W'($rtoi((th(k + 1) - th(k)) * 2.0 * SCALE + 0.5)) : '0;
  endfunction
  function automatic logic [DATA_W-1:0] c_q(input int k);
    return k < 6 ? DATA_W'($rtoi((th(k) - (th(k + 1) - th(k)) * real'(k)) * SCALE + 0.5)) : '0;
  endfunction
  localparam logic [DATA_W-1:0] M_TAB [8] = '{m_q(0), m_q(1), m_q(2), m_q(3), m_q(4), m_q(5), m_q(6), m_q(7)};
  localparam logic [DATA_W-1:0] C_TAB [8] = '{c_q(0), c_q(1), c_q(2), c_q(3), c_q(4), c_q(5), c_q(6), c_q(7)};
  logic adv, mode_in, v1, v2, m1, m2;
`ifdef ACT_PWL_SIGMOID_EN
  assign mode_in = in_mode;
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign mode_in = 1'b0;
`endif
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_mode <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      out_mode <= m2;
    end
  always_ff @(posedge clk)
    if (adv) begin
      m1 <= mode_in;
      m2 <= m1;
    end
  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_W-1:0] x, xe, s2_t, y, yc, res;
    logic [DATA_W-1:0] mag, s1_mag, t, out_r;
    logic [2:0] seg, s1_seg;
    logic [2*DATA_W-1:0] prod;
    logic s1_neg, s2_neg;
    always_comb begin
      x = in_data[k*DATA_W +: DATA_W];
      xe = mode_in ? (x >>> 1) : x;
      mag = xe[DATA_W-1] ? (xe == MIN ? MAX : -xe) : xe;
      seg = '0;
      for (int j = 1; j < 7; j++) if (mag >= DATA_W'(j << (FRAC_W - 1))) seg = 3'(j);
    end
    always_comb begin
      prod = {{DATA_W{1'b0}}, M_TAB[s1_seg]} * {{DATA_W{1'b0}}, s1_mag};
      t = s1_seg == 3'd6 ? LIM : DATA_W'((prod + RND) >> FRAC_W) + C_TAB[s1_seg];
    end
`ifdef ACT_PWL_SIGMOID_EN
    logic signed [DATA_W-1:0] ys;
`endif
    always_comb begin
      y = s2_neg ? -s2_t : s2_t;
      yc = y > LIM ? LIM : (y < -LIM ? -LIM : y);
`ifdef ACT_PWL_SIGMOID_EN
      ys = (yc >>> 1) + HALF;
      res = m2 ? (ys < 0 ? '0 : (ys > LIM ? LIM : ys)) : yc;
`else
      res = yc;
`endif
    end
    always_ff @(posedge clk)
      if (adv) begin
        s1_neg <= xe[DATA_W-1];
        s1_mag <= mag;
        s1_seg <= seg;
        s2_neg <= s1_neg;
        s2_t <= t;
      end
    always_ff @(posedge clk)
      if (rst) out_r <= '0;
      else if (adv) out_r <= res;
    assign out_data[k*DATA_W +: DATA_W] = out_r;
  end
endmodule
